// File: rtl/xo_pkg.sv
// Shared definitions for the noughts-and-crosses CPU move picker.
// Holds board geometry, the full-board pattern and the picker FSM states.
package xo_pkg;

    localparam int unsigned NUM_CELLS = 9;
    localparam int unsigned CELL_W    = 4;
    localparam int unsigned TRY_W     = 4;
    localparam int unsigned IDX_SPAN  = 2 ** CELL_W;

    localparam logic [NUM_CELLS-1:0] BOARD_FULL = 9'h1FF;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_DRAW  = 3'd1,
        ST_CHECK = 3'd2,
        ST_SCAN  = 3'd3,
        ST_DONE  = 3'd4,
        ST_FULL  = 3'd5
    } state_e;

endpackage

// File: rtl/cpu_move_picker_if.sv
// Request/response bundle between a game controller and the CPU move picker.
//   i_Req         controller -> picker  request one move
//   i_Occupied    controller -> picker  board occupancy, bit k = cell k taken
//   i_LFSR_Data   lfsr       -> picker  current pseudo-random value
//   o_LFSR_Enable picker -> lfsr        advance the LFSR one step
//   o_Busy        picker -> controller  request in progress
//   o_Move        picker -> controller  chosen cell 0..8
//   o_Move_Valid  picker -> controller  one-cycle pulse when o_Move updates
//   o_Board_Full  picker -> controller  one-cycle pulse when no cell is free
interface cpu_move_picker_if;
    import xo_pkg::*;

    logic                 i_Req;
    logic [NUM_CELLS-1:0] i_Occupied;
    logic [CELL_W-1:0]    i_LFSR_Data;
    logic                 o_LFSR_Enable;
    logic                 o_Busy;
    logic [CELL_W-1:0]    o_Move;
    logic                 o_Move_Valid;
    logic                 o_Board_Full;

    modport master (
        output i_Req, i_Occupied, i_LFSR_Data,
        input  o_LFSR_Enable, o_Busy, o_Move, o_Move_Valid, o_Board_Full
    );

    modport slave (
        input  i_Req, i_Occupied, i_LFSR_Data,
        output o_LFSR_Enable, o_Busy, o_Move, o_Move_Valid, o_Board_Full
    );

endinterface

// File: rtl/cpu_move_picker.sv
// CPU move picker: chooses a free cell by drawing random values from an
// upstream LFSR, falling back to an ascending linear scan after MAX_TRIES
// rejected draws. Reports a one-cycle board-full pulse if no cell is free.
// Ports:
//   i_Clk    clock, rising edge
//   i_Rst_n  asynchronous active-low reset
//   bus      cpu_move_picker_if.slave (request, board, LFSR and results)
// Every output is a flop loaded from the next-state decode, so nothing
// reaches the outputs combinationally from the inputs.
module cpu_move_picker
    import xo_pkg::*;
#(
    parameter int unsigned MAX_TRIES = 8
) (
    input  logic              i_Clk,
    input  logic              i_Rst_n,
    cpu_move_picker_if.slave  bus
);

    state_e               state, state_nxt;
    logic [NUM_CELLS-1:0] r_board, board_nxt;
    logic [TRY_W-1:0]     tries, tries_nxt;
    logic [CELL_W-1:0]    scan_idx, scan_nxt;
    logic [CELL_W-1:0]    move_q, move_nxt;
    logic                 lfsr_en_q, busy_q, valid_q, full_q;

    // Board padded with "occupied" above cell 8 so draws 9..15 always reject.
    logic [IDX_SPAN-1:0]  board_ext;
    logic                 cand_free;
    logic                 scan_free;
    logic [TRY_W-1:0]     tries_inc;

    assign board_ext = {{(IDX_SPAN - NUM_CELLS){1'b1}}, r_board};
    assign cand_free = ~board_ext[bus.i_LFSR_Data];
    assign scan_free = ~board_ext[scan_idx];
    assign tries_inc = tries + TRY_W'(1);

    // State and datapath registers.
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state     <= ST_IDLE;
            r_board   <= '0;
            tries     <= '0;
            scan_idx  <= '0;
            move_q    <= '0;
            lfsr_en_q <= 1'b0;
            busy_q    <= 1'b0;
            valid_q   <= 1'b0;
            full_q    <= 1'b0;
        end else begin
            state     <= state_nxt;
            r_board   <= board_nxt;
            tries     <= tries_nxt;
            scan_idx  <= scan_nxt;
            move_q    <= move_nxt;
            lfsr_en_q <= (state_nxt == ST_DRAW);
            busy_q    <= (state_nxt != ST_IDLE);
            valid_q   <= (state_nxt == ST_DONE);
            full_q    <= (state_nxt == ST_FULL);
        end
    end

    // Next-state and datapath decode.
    always_comb begin
        state_nxt = state;
        board_nxt = r_board;
        tries_nxt = tries;
        scan_nxt  = scan_idx;
        move_nxt  = move_q;

        case (state)
            ST_IDLE: begin
                if (bus.i_Req) begin
                    board_nxt = bus.i_Occupied;
                    tries_nxt = '0;
                    scan_nxt  = '0;
                    // Decide on the sampled occupancy so FULL costs no extra cycle.
                    state_nxt = (bus.i_Occupied == BOARD_FULL) ? ST_FULL : ST_DRAW;
                end
            end

            ST_DRAW: begin
                state_nxt = ST_CHECK;
            end

            ST_CHECK: begin
                if (cand_free) begin
                    move_nxt  = bus.i_LFSR_Data;
                    state_nxt = ST_DONE;
                end else begin
                    tries_nxt = tries_inc;
                    if (tries_inc == TRY_W'(MAX_TRIES)) begin
                        scan_nxt  = '0;
                        state_nxt = ST_SCAN;
                    end else begin
                        state_nxt = ST_DRAW;
                    end
                end
            end

            ST_SCAN: begin
                // A non-full board always has a free cell by index 8.
                if (scan_free || (scan_idx == CELL_W'(NUM_CELLS - 1))) begin
                    move_nxt  = scan_idx;
                    state_nxt = ST_DONE;
                end else begin
                    scan_nxt = scan_idx + CELL_W'(1);
                end
            end

            ST_DONE: begin
                state_nxt = ST_IDLE;
            end

            ST_FULL: begin
                state_nxt = ST_IDLE;
            end

            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    assign bus.o_LFSR_Enable = lfsr_en_q;
    assign bus.o_Busy        = busy_q;
    assign bus.o_Move        = move_q;
    assign bus.o_Move_Valid  = valid_q;
    assign bus.o_Board_Full  = full_q;

endmodule

// File: tb/tb_cpu_move_picker.sv
// Self-checking bench for cpu_move_picker. The bench plays the upstream LFSR:
// after every edge that ends a cycle with o_LFSR_Enable high it presents the
// next value from draw_q (15 once the queue is empty).
module tb_cpu_move_picker;

    localparam int unsigned MAX_T = 8;

    logic i_Clk;
    logic i_Rst_n;

    cpu_move_picker_if bus ();

    cpu_move_picker #(.MAX_TRIES(MAX_T)) dut (
        .i_Clk   (i_Clk),
        .i_Rst_n (i_Rst_n),
        .bus     (bus.slave)
    );

    initial i_Clk = 1'b0;
    always #5 i_Clk = ~i_Clk;

    int errors = 0;
    int checks = 0;

    logic [3:0] draw_q[$];
    logic [3:0] exp_last_move;

    // Observations from the most recent run_req.
    int         ob_en, ob_valid, ob_full, ob_vc, ob_fc, ob_overlap, ob_busy_bad;
    logic [3:0] ob_move;
    logic [3:0] ob_move_after;
    logic       ob_busy_after;
    bit         ob_done;

    // Reference model: expected move, enable count and cycle (after E0) of
    // the terminal pulse, from the picker's rules over the draw sequence.
    function automatic void model(input logic [8:0] b, input logic [3:0] dq[$],
                                  output int en, output int vc, output int mv,
                                  output bit full);
        en = 0; vc = 0; mv = -1; full = 0;
        if (b == 9'h1FF) begin
            full = 1; vc = 1;
            return;
        end
        for (int t = 0; t < int'(MAX_T); t++) begin
            int d;
            d = (t < dq.size()) ? int'(dq[t]) : 15;
            en++;
            if (d <= 8 && b[d] == 1'b0) begin
                mv = d; vc = 2 * t + 3;
                return;
            end
        end
        for (int c = 0; c < 9; c++) begin
            if (b[c] == 1'b0) begin
                mv = c; vc = 2 * int'(MAX_T) + 2 + c;
                return;
            end
        end
    endfunction

    // Issue one request and watch it to completion (cycle 1 = cycle after E0).
    task automatic run_req(input logic [8:0] board, input bit noise);
        bit pop;
        bit term;
        term = 0;
        ob_en = 0; ob_valid = 0; ob_full = 0; ob_vc = -1; ob_fc = -1;
        ob_overlap = 0; ob_busy_bad = 0; ob_move = 'x; ob_done = 0;
        @(negedge i_Clk);
        bus.i_Occupied  = board;
        bus.i_Req       = 1'b1;
        bus.i_LFSR_Data = 4'($urandom_range(0, 15));
        @(posedge i_Clk);
        #1 bus.i_Req = 1'b0;
        for (int cyc = 1; cyc <= 200 && !ob_done; cyc++) begin
            @(negedge i_Clk);
            pop = bus.o_LFSR_Enable;
            if (bus.o_LFSR_Enable) ob_en++;
            if (bus.o_Move_Valid) begin
                ob_valid++; ob_vc = cyc; ob_move = bus.o_Move; term = 1;
            end
            if (bus.o_Board_Full) begin
                ob_full++; ob_fc = cyc; term = 1;
            end
            if (int'(bus.o_LFSR_Enable) + int'(bus.o_Move_Valid) + int'(bus.o_Board_Full) > 1)
                ob_overlap++;
            if (!bus.o_Busy) ob_busy_bad++;
            @(posedge i_Clk);
            #1;
            if (pop) bus.i_LFSR_Data = (draw_q.size() > 0) ? draw_q.pop_front() : 4'd15;
            if (term) begin
                ob_done = 1;
                bus.i_Req = 1'b0;
            end else if (noise) begin
                bus.i_Req      = 1'($urandom);
                bus.i_Occupied = 9'($urandom);
            end
        end
        @(negedge i_Clk);
        ob_busy_after = bus.o_Busy;
        ob_move_after = bus.o_Move;
    endtask

    // Run one request against the model and compare everything observed.
    task automatic check_req(input string tag, input logic [8:0] board, input bit noise);
        int e_en, e_vc, e_mv;
        bit e_full;
        model(board, draw_q, e_en, e_vc, e_mv, e_full);
        run_req(board, noise);
        checks++;
        if (!ob_done) begin
            errors++;
            $display("FAIL %s timeout: no valid/full pulse within budget", tag);
        end
        checks++;
        if (ob_en != e_en) begin
            errors++;
            $display("FAIL %s enable_pulses: got %0d expected %0d", tag, ob_en, e_en);
        end
        checks++;
        if (ob_overlap != 0) begin
            errors++;
            $display("FAIL %s overlap: %0d cycles with multiple pulses, expected 0", tag, ob_overlap);
        end
        checks++;
        if (ob_busy_bad != 0 || ob_busy_after !== 1'b0) begin
            errors++;
            $display("FAIL %s busy: low-while-busy=%0d after=%b expected 0/0", tag, ob_busy_bad, ob_busy_after);
        end
        if (e_full) begin
            checks++;
            if (ob_full != 1 || ob_fc != e_vc || ob_valid != 0) begin
                errors++;
                $display("FAIL %s full_pulse: full=%0d at %0d valid=%0d expected 1 at %0d valid 0",
                         tag, ob_full, ob_fc, ob_valid, e_vc);
            end
            checks++;
            if (ob_move_after !== exp_last_move) begin
                errors++;
                $display("FAIL %s move_kept: got %0d expected %0d", tag, ob_move_after, exp_last_move);
            end
        end else begin
            checks++;
            if (ob_valid != 1 || ob_vc != e_vc || ob_full != 0) begin
                errors++;
                $display("FAIL %s valid_pulse: valid=%0d at %0d full=%0d expected 1 at %0d full 0",
                         tag, ob_valid, ob_vc, ob_full, e_vc);
            end
            checks++;
            if (ob_move !== 4'(e_mv) || ob_move_after !== 4'(e_mv)) begin
                errors++;
                $display("FAIL %s move: got %0d (later %0d) expected %0d", tag, ob_move, ob_move_after, e_mv);
            end
            exp_last_move = 4'(e_mv);
        end
        draw_q.delete();
    endtask

    task automatic test_reset();
        i_Rst_n = 1'b0;
        bus.i_Req = 1'b0;
        bus.i_Occupied = '0;
        bus.i_LFSR_Data = '0;
        exp_last_move = '0;
        repeat (3) @(negedge i_Clk);
        checks++;
        if ({bus.o_Busy, bus.o_LFSR_Enable, bus.o_Move_Valid, bus.o_Board_Full, bus.o_Move} !== 8'h00) begin
            errors++;
            $display("FAIL reset_outputs: busy=%b en=%b valid=%b full=%b move=%0d expected all 0",
                     bus.o_Busy, bus.o_LFSR_Enable, bus.o_Move_Valid, bus.o_Board_Full, bus.o_Move);
        end
        i_Rst_n = 1'b1;
        repeat (2) @(negedge i_Clk);
        checks++;
        if (bus.o_Busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset: busy=%b expected 0", bus.o_Busy);
        end
    endtask

    task automatic test_basic();
        draw_q = '{4'd5};
        check_req("basic", 9'h000, 0);
    endtask

    task automatic test_full();
        check_req("full", 9'h1FF, 0);
    endtask

    task automatic test_reject();
        draw_q = '{4'd12, 4'd0, 4'd3};
        check_req("reject", 9'h001, 0);
    endtask

    task automatic test_scan();
        check_req("scan", 9'h0FF, 0);
    endtask

    task automatic test_busy_ignore();
        draw_q = '{4'd12, 4'd4, 4'd6};
        check_req("busy_ignore", 9'h010, 1);
    endtask

    task automatic test_reset_mid();
        int pulses;
        pulses = 0;
        @(negedge i_Clk);
        bus.i_Occupied = 9'h000;
        bus.i_Req = 1'b1;
        @(posedge i_Clk);
        #1 bus.i_Req = 1'b0;
        @(posedge i_Clk);
        #2 i_Rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.o_Busy, bus.o_LFSR_Enable, bus.o_Move_Valid, bus.o_Board_Full, bus.o_Move} !== 8'h00) begin
            errors++;
            $display("FAIL reset_mid_outputs: busy=%b en=%b valid=%b full=%b move=%0d expected all 0",
                     bus.o_Busy, bus.o_LFSR_Enable, bus.o_Move_Valid, bus.o_Board_Full, bus.o_Move);
        end
        repeat (3) begin
            @(negedge i_Clk);
            if (bus.o_Move_Valid || bus.o_Board_Full || bus.o_LFSR_Enable) pulses++;
        end
        i_Rst_n = 1'b1;
        repeat (3) begin
            @(negedge i_Clk);
            if (bus.o_Move_Valid || bus.o_Board_Full || bus.o_LFSR_Enable) pulses++;
        end
        checks++;
        if (pulses != 0) begin
            errors++;
            $display("FAIL reset_mid_pulses: got %0d pulse cycles expected 0", pulses);
        end
        exp_last_move = '0;
        draw_q = '{4'd7};
        check_req("after_reset", 9'h000, 0);
    endtask

    task automatic test_back_to_back();
        int vcyc[$];
        logic [3:0] vmove[$];
        bit pop;
        draw_q = '{4'd2, 4'd6};
        @(negedge i_Clk);
        bus.i_Occupied = 9'h000;
        bus.i_Req = 1'b1;
        @(posedge i_Clk);
        for (int cyc = 1; cyc <= 8; cyc++) begin
            @(negedge i_Clk);
            pop = bus.o_LFSR_Enable;
            if (bus.o_Move_Valid) begin
                vcyc.push_back(cyc);
                vmove.push_back(bus.o_Move);
            end
            @(posedge i_Clk);
            #1;
            if (pop) bus.i_LFSR_Data = (draw_q.size() > 0) ? draw_q.pop_front() : 4'd15;
            if (cyc == 7) bus.i_Req = 1'b0;
        end
        checks++;
        if (vcyc.size() != 2 || vcyc[0] != 3 || vcyc[1] != 7) begin
            errors++;
            $display("FAIL back_to_back_timing: %0d pulses (first %0d, second %0d) expected 2 at 3 and 7",
                     vcyc.size(), (vcyc.size() > 0) ? vcyc[0] : -1, (vcyc.size() > 1) ? vcyc[1] : -1);
        end else begin
            checks++;
            if (vmove[0] !== 4'd2 || vmove[1] !== 4'd6) begin
                errors++;
                $display("FAIL back_to_back_moves: got %0d,%0d expected 2,6", vmove[0], vmove[1]);
            end
        end
        exp_last_move = 4'd6;
        draw_q.delete();
        repeat (12) @(negedge i_Clk);
    endtask

    task automatic test_random();
        logic [8:0] b;
        int n;
        for (int it = 0; it < 40; it++) begin
            b = ($urandom_range(0, 7) == 0) ? 9'h1FF : 9'($urandom);
            n = $urandom_range(0, 10);
            for (int k = 0; k < n; k++) draw_q.push_back(4'($urandom_range(0, 15)));
            check_req($sformatf("random%0d", it), b, 1'($urandom));
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_full();
        test_reject();
        test_scan();
        test_busy_ignore();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
